noc_inj_sched: RTL and testbench
================================

Name: noc_inj_sched

Overview:
- Per-PE injection scheduler for the deflection BFT.
- Shares one NoC injection port (the peo slot of a leaf switch) among NREQ local requesters using round-robin arbitration.
- Throttles injection to RATE percent of cycles and stops after LIMIT packets; then drains and raises done for the done_pe reduction.
- Also counts valid packets delivered on pei for statistics.

Parameters:
N, 2, number of PEs on the NoC
D_W, 32, payload width
A_W, $clog2(N)+1, address width
NREQ, 4, number of local requesters (power of two, >=2)
POSX, 0, this PE's index (address of self)
LIMIT, 1024, packets to inject before done
RATE, 100, injection rate in percent (1..100)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
ce  in  1  clock enable; all state frozen when low (rst still acts)
start  in  1  one-cycle pulse; begins an injection run
req_valid  in  NREQ  per-requester valid
req_addr  in  NREQ*A_W  destination per requester, packed; requester i occupies [i*A_W +: A_W]
req_data  in  NREQ*D_W  payload per requester, packed
req_ready  out  NREQ  per-requester accept (one-hot or zero)
net_rdy  in  1  leaf switch accepts peo this cycle
peo  out  A_W+D_W+2  packet to NoC: {valid, tag, addr, data}; tag = 1 marks the last packet of the run
pei  in  A_W+D_W+2  packet from NoC, same format
sent_cnt  out  32  packets accepted by the network this run
rcv_cnt  out  32  valid pei packets whose addr == POSX
busy  out  1  state is RUN or DRAIN
done  out  1  state is DONE

Behaviour:
- Reset values: peo = 0, req_ready = 0, sent_cnt = 0, rcv_cnt = 0, busy = 0, done = 0. FSM state = IDLE. RR pointer = 0. Rate accumulator = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DRAIN in the cycle the LIMIT-th packet is loaded into the output register.
  - DRAIN -> DONE when the output register is accepted (valid & net_rdy) or already empty.
  - DONE -> RUN on start. Entering RUN from DONE clears sent_cnt, rcv_cnt and the accumulator.
  - start in RUN or DRAIN is ignored.
- Rate accumulator (8 bits):
  - Each ce cycle in RUN, acc <= acc + RATE, saturating at 200.
  - A token exists when acc >= 100. On a load, acc <= acc + RATE - 100.
  - RATE = 100 therefore allows one load every cycle.
- Output register:
  - Free when peo.valid == 0 or net_rdy == 1.
  - Load condition: state RUN & ce & free & token & some req_valid & issued < LIMIT. When met, it loads the granted requester's packet and pulses req_ready[g] for that same cycle.
  - The handshake is combinational ready on a registered output: the request transfers when req_valid[g] & req_ready[g].
  - If free but not loading, valid clears once the held packet is accepted.
  - Packet latency: 1 cycle from handshake to peo.
- Arbitration:
  - Round-robin starting at the pointer. g = first asserted req_valid at or after ptr, modulo NREQ.
  - After a grant, ptr <= g+1 (wraps at NREQ).
  - No grant means the pointer is unchanged.
- Tag bit = 1 only on the LIMIT-th packet.
- sent_cnt increments on peo.valid & net_rdy & ce.
- rcv_cnt increments on pei.valid & pei.addr == POSX & ce, in any state except IDLE.
- Counter widths: 32 bits, wrapping. An issued counter (internal) tracks loads separately from sent_cnt.
- If net_rdy is held low, peo holds its value, no further loads occur, and the accumulator still saturates.
- LIMIT = 0: RUN -> DRAIN -> DONE in two cycles with nothing injected.
- Asynchronous rst mid-run: all state is cleared immediately and the in-flight peo packet is dropped.

Decomposition:
- Shared package noc_pkg holds:
  - packet field offsets: VALID_BIT = A_W+D_W+1, TAG_BIT = A_W+D_W
  - the packet width function
  - the FSM state encoding (2-bit IDLE=0, RUN=1, DRAIN=2, DONE=3)
- One sub-module, rr_arbiter (NREQ request in, one-hot grant out, pointer update on an advance input), reused by other NoC controllers.

Test Plan:
1. Reset, then LIMIT=4, RATE=100, req_valid=4'b1111 steady, net_rdy=1, start pulse.
   - Grants go 0,1,2,3 on consecutive cycles; peo valid on cycles 1..4 with addr/data from requesters 0..3.
   - tag=1 only on the 4th packet; done rises 2 cycles after the last load; sent_cnt=4.
2. RATE=50, LIMIT=8, all requesters valid, net_rdy=1.
   - Loads occur every second cycle, giving 8 packets in 16±1 cycles.
3. LIMIT=3, net_rdy=0 for 5 cycles after the first load.
   - peo holds packet 0 unchanged and req_ready stays 0.
   - After net_rdy rises, the remaining two packets follow, then done.
4. req_valid=4'b0100 only, then 4'b1001.
   - Grants 2, then 3→wrap gives 0, then 3; pointer order is verified.
5. pei streams 10 valid packets, 6 with addr==POSX, during RUN.
   - rcv_cnt=6; no count in IDLE.
6. Assert rst mid-run after 2 packets of LIMIT=8.
   - All outputs are 0 immediately; a new start runs a full 8-packet sequence.

Source files
------------

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC packet layout helpers and injection FSM encoding
package noc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [8:0] ACC_TOKEN = 9'd100;
  localparam logic [8:0] ACC_MAX   = 9'd200;

  // Packet layout is {valid, tag, addr, data}, so the offsets depend on A_W/D_W.
  function automatic int pkt_w(input int a_w, input int d_w);
    return a_w + d_w + 2;
  endfunction

  function automatic int valid_bit(input int a_w, input int d_w);
    return a_w + d_w + 1;
  endfunction

  function automatic int tag_bit(input int a_w, input int d_w);
    return a_w + d_w;
  endfunction

endpackage

// File: rtl/noc_inj_sched_rr_arbiter.sv
// rtl/noc_inj_sched_rr_arbiter.sv - round-robin arbiter with one-hot grant and advance-driven pointer
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            adv_i,
  output logic [NREQ-1:0] grant_o
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx, gidx;
  logic          found;

  // NREQ is a power of two, so pointer arithmetic wraps for free.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    gidx    = ptr_q;
    idx     = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr_q + PW'(i);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        gidx         = idx;
        found        = 1'b1;
      end
    end
    ptr_d = (adv_i && found) ? gidx + PW'(1) : ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/noc_inj_sched.sv
// rtl/noc_inj_sched.sv - per-PE NoC injection scheduler: RR arbitration, rate throttle, run limit
module noc_inj_sched
  import noc_pkg::*;
#(
  parameter int N     = 2,
  parameter int D_W   = 32,
  parameter int A_W   = $clog2(N) + 1,
  parameter int NREQ  = 4,
  parameter int POSX  = 0,
  parameter int LIMIT = 1024,
  parameter int RATE  = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   start,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*A_W-1:0]    req_addr,
  input  logic [NREQ*D_W-1:0]    req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   net_rdy,
  output logic [A_W+D_W+1:0]     peo,
  input  logic [A_W+D_W+1:0]     pei,
  output logic [31:0]            sent_cnt,
  output logic [31:0]            rcv_cnt,
  output logic                   busy,
  output logic                   done
);

  localparam int          PKT_W     = pkt_w(A_W, D_W);
  localparam int          VALID_BIT = valid_bit(A_W, D_W);
  localparam int          TAG_BIT   = tag_bit(A_W, D_W);
  localparam logic [31:0] LIMIT32   = 32'(LIMIT);

  state_e             st_q, st_d;
  logic [7:0]         acc_q, acc_d;
  logic [8:0]         acc_sum;
  logic [31:0]        issued_q, issued_d, sent_q, sent_d, rcv_q, rcv_d;
  logic [PKT_W-1:0]   peo_q, peo_d;
  logic [NREQ-1:0]    grant;
  logic [A_W-1:0]     g_addr;
  logic [D_W-1:0]     g_data;
  logic               peo_valid, free, token, load, last, pei_hit;
  logic               pei_unused;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_valid),
    .adv_i   (load),
    .grant_o (grant)
  );

  always_comb begin
    g_addr = '0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        g_addr = req_addr[i*A_W +: A_W];
        g_data = req_data[i*D_W +: D_W];
      end
    end
  end

  assign peo_valid  = peo_q[VALID_BIT];
  assign free       = !peo_valid || net_rdy;
  assign token      = {1'b0, acc_q} >= ACC_TOKEN;
  assign load       = (st_q == ST_RUN) && ce && free && token && (|req_valid) && (issued_q < LIMIT32);
  assign last       = (issued_q + 32'd1) == LIMIT32;
  assign pei_hit    = pei[VALID_BIT] && (pei[D_W +: A_W] == A_W'(POSX));
  assign pei_unused = ^{pei[TAG_BIT], pei[D_W-1:0]};
  assign acc_sum    = {1'b0, acc_q} + 9'(RATE);

  always_comb begin
    st_d     = st_q;
    acc_d    = acc_q;
    issued_d = issued_q;
    sent_d   = sent_q;
    rcv_d    = rcv_q;
    peo_d    = peo_q;
    if (ce) begin
      if (peo_valid && net_rdy) sent_d = sent_q + 32'd1;
      if (pei_hit && st_q != ST_IDLE) rcv_d = rcv_q + 32'd1;
      if (load) begin
        peo_d    = {1'b1, last, g_addr, g_data};
        issued_d = issued_q + 32'd1;
      end else if (free) begin
        peo_d[VALID_BIT] = 1'b0;
      end
      case (st_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            st_d     = ST_RUN;
            acc_d    = '0;
            issued_d = '0;
            sent_d   = '0;
            rcv_d    = '0;
          end
        end
        ST_RUN: begin
          if (load) acc_d = 8'(acc_sum - ACC_TOKEN);
          else      acc_d = (acc_sum > ACC_MAX) ? 8'(ACC_MAX) : acc_sum[7:0];
          // Second term covers LIMIT=0, where no load ever happens.
          if ((load && last) || issued_q >= LIMIT32) st_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (free) st_d = ST_DONE;
        end
        default: st_d = st_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= ST_IDLE;
      acc_q    <= '0;
      issued_q <= '0;
      sent_q   <= '0;
      rcv_q    <= '0;
      peo_q    <= '0;
    end else begin
      st_q     <= st_d;
      acc_q    <= acc_d;
      issued_q <= issued_d;
      sent_q   <= sent_d;
      rcv_q    <= rcv_d;
      peo_q    <= peo_d;
    end
  end

  assign req_ready = load ? grant : '0;
  assign peo       = peo_q;
  assign sent_cnt  = sent_q;
  assign rcv_cnt   = rcv_q;
  assign busy      = (st_q == ST_RUN) || (st_q == ST_DRAIN);
  assign done      = (st_q == ST_DONE);

endmodule

// File: tb/tb_noc_inj_sched.sv
// tb/tb_noc_inj_sched.sv - directed bench for noc_inj_sched across several LIMIT/RATE configurations
module tb_noc_inj_sched;

  logic        clk = 1'b0;
  logic        rst, ce, net_rdy;
  logic        start_a, start_b, start_c, start_z;
  logic [3:0]  req_valid;
  logic [7:0]  req_addr;
  logic [127:0] req_data;
  logic [35:0] pei;

  logic [3:0]  rr_a, rr_b, rr_c, rr_z;
  logic [35:0] peo_a, peo_b, peo_c, peo_z;
  logic [31:0] sent_a, sent_b, sent_c, sent_z;
  logic [31:0] rcv_a, rcv_b, rcv_c, rcv_z;
  logic        busy_a, busy_b, busy_c, busy_z;
  logic        done_a, done_b, done_c, done_z;

  int vectors = 0;
  int miscompares = 0;
  logic [1:0] pei_tab [10] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0, 2'd1, 2'd0};

  always #5 clk = ~clk;

  noc_inj_sched #(.N(2), .D_W(32), .NREQ(4), .POSX(0), .LIMIT(4), .RATE(100)) u_a (
    .clk(clk), .rst(rst), .ce(ce), .start(start_a), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(rr_a), .net_rdy(net_rdy), .peo(peo_a), .pei(pei),
    .sent_cnt(sent_a), .rcv_cnt(rcv_a), .busy(busy_a), .done(done_a));

  noc_inj_sched #(.N(2), .D_W(32), .NREQ(4), .POSX(0), .LIMIT(8), .RATE(50)) u_b (
    .clk(clk), .rst(rst), .ce(ce), .start(start_b), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(rr_b), .net_rdy(net_rdy), .peo(peo_b), .pei(pei),
    .sent_cnt(sent_b), .rcv_cnt(rcv_b), .busy(busy_b), .done(done_b));

  noc_inj_sched #(.N(2), .D_W(32), .NREQ(4), .POSX(0), .LIMIT(3), .RATE(100)) u_c (
    .clk(clk), .rst(rst), .ce(ce), .start(start_c), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(rr_c), .net_rdy(net_rdy), .peo(peo_c), .pei(pei),
    .sent_cnt(sent_c), .rcv_cnt(rcv_c), .busy(busy_c), .done(done_c));

  noc_inj_sched #(.N(2), .D_W(32), .NREQ(4), .POSX(0), .LIMIT(0), .RATE(100)) u_z (
    .clk(clk), .rst(rst), .ce(ce), .start(start_z), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(rr_z), .net_rdy(net_rdy), .peo(peo_z), .pei(pei),
    .sent_cnt(sent_z), .rcv_cnt(rcv_z), .busy(busy_z), .done(done_z));

  function automatic logic [35:0] pkt(input logic v, input logic t, input int i);
    return {v, t, 2'(i), 32'hA000_0000 + 32'(i)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RATE=50, LIMIT=8: loads land on odd cycles 3..17, done on cycle 19.
  task automatic run_b(input bit with_pei);
    logic [3:0] e;
    start_b = 1'b1;
    @(negedge clk);
    chk("b_rr_start", rr_b, 4'h0);
    tick();
    start_b = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      pei = (with_pei && k <= 10) ? {1'b1, 1'b0, pei_tab[k-1], 32'h5EED_0000 + 32'(k)} : '0;
      @(negedge clk);
      e = (k >= 3 && k <= 17 && (k % 2) == 1) ? 4'(1 << (((k - 3) / 2) % 4)) : 4'h0;
      chk($sformatf("b_rr_k%0d", k), rr_b, e);
      chk($sformatf("b_done_k%0d", k), done_b, k == 19);
      if (k == 18) chk("b_last_pkt", peo_b, pkt(1'b1, 1'b1, 3));
      if (k == 19) begin
        chk("b_sent", sent_b, 32'd8);
        chk("b_rcv", rcv_b, with_pei ? 32'd6 : 32'd0);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; net_rdy = 1'b1; pei = '0; req_valid = '0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_z = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*2 +: 2]   = 2'(i);
      req_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    end
    tick(); tick();
    chk("rst_peo", peo_a, 36'h0);
    chk("rst_rr", rr_a, 4'h0);
    chk("rst_sent", sent_a, 32'd0);
    chk("rst_rcv", rcv_a, 32'd0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    rst = 1'b0;
    tick();

    // LIMIT=4 full-rate run on u_a, LIMIT=0 on u_z in parallel
    req_valid = 4'hF; start_a = 1'b1; start_z = 1'b1;
    @(negedge clk); chk("a_k0_rr", rr_a, 4'h0); tick();
    start_a = 1'b0; start_z = 1'b0;
    @(negedge clk); chk("a_k1_rr", rr_a, 4'h0); chk("a_k1_busy", busy_a, 1'b1); chk("z_k1_busy", busy_z, 1'b1); tick();
    @(negedge clk); chk("a_k2_rr", rr_a, 4'h1); chk("a_k2_peo", peo_a, 36'h0); chk("z_k2_done", done_z, 1'b0); tick();
    @(negedge clk); chk("a_k3_rr", rr_a, 4'h2); chk("a_k3_peo", peo_a, pkt(1'b1, 1'b0, 0)); chk("z_k3_done", done_z, 1'b1);
    chk("z_k3_sent", sent_z, 32'd0); chk("z_k3_peo", peo_z, 36'h0); tick();
    @(negedge clk); chk("a_k4_rr", rr_a, 4'h4); chk("a_k4_peo", peo_a, pkt(1'b1, 1'b0, 1)); chk("a_k4_sent", sent_a, 32'd1); tick();
    @(negedge clk); chk("a_k5_rr", rr_a, 4'h8); chk("a_k5_peo", peo_a, pkt(1'b1, 1'b0, 2)); tick();
    @(negedge clk); chk("a_k6_rr", rr_a, 4'h0); chk("a_k6_peo", peo_a, pkt(1'b1, 1'b1, 3));
    chk("a_k6_busy", busy_a, 1'b1); chk("a_k6_done", done_a, 1'b0); chk("a_k6_sent", sent_a, 32'd3); tick();
    @(negedge clk); chk("a_k7_done", done_a, 1'b1); chk("a_k7_busy", busy_a, 1'b0);
    chk("a_k7_sent", sent_a, 32'd4); chk("a_k7_peo", peo_a, pkt(1'b0, 1'b1, 3)); tick();

    // Pointer order: 0100 then 1001 from DONE restart
    req_valid = 4'b0100; start_a = 1'b1; tick();
    start_a = 1'b0;
    @(negedge clk); chk("a_m1_sent_clr", sent_a, 32'd0); chk("a_m1_rr", rr_a, 4'h0); tick();
    @(negedge clk); chk("a_m2_rr", rr_a, 4'b0100); tick();
    req_valid = 4'b1001;
    @(negedge clk); chk("a_m3_rr", rr_a, 4'b1000); chk("a_m3_peo", peo_a, pkt(1'b1, 1'b0, 2)); tick();
    @(negedge clk); chk("a_m4_rr", rr_a, 4'b0001); chk("a_m4_peo", peo_a, pkt(1'b1, 1'b0, 3)); tick();
    @(negedge clk); chk("a_m5_rr", rr_a, 4'b1000); chk("a_m5_peo", peo_a, pkt(1'b1, 1'b0, 0)); tick();
    @(negedge clk); chk("a_m6_rr", rr_a, 4'b0000); chk("a_m6_peo", peo_a, pkt(1'b1, 1'b1, 3)); tick();
    @(negedge clk); chk("a_m7_done", done_a, 1'b1); tick();

    // RATE=50 run with pei traffic; u_c stays idle and must not count
    req_valid = 4'hF;
    run_b(1'b1);
    chk("c_idle_rcv", rcv_c, 32'd0);

    // LIMIT=3 with net_rdy low for 5 cycles after the first load
    start_c = 1'b1; tick();
    start_c = 1'b0;
    @(negedge clk); chk("c_q1_rr", rr_c, 4'h0); tick();
    @(negedge clk); chk("c_q2_rr", rr_c, 4'h1); tick();
    net_rdy = 1'b0;
    for (int q = 3; q <= 7; q++) begin
      @(negedge clk);
      chk($sformatf("c_hold_peo_q%0d", q), peo_c, pkt(1'b1, 1'b0, 0));
      chk($sformatf("c_hold_rr_q%0d", q), rr_c, 4'h0);
      chk($sformatf("c_hold_sent_q%0d", q), sent_c, 32'd0);
      tick();
    end
    net_rdy = 1'b1;
    @(negedge clk); chk("c_q8_rr", rr_c, 4'h2); chk("c_q8_peo", peo_c, pkt(1'b1, 1'b0, 0)); tick();
    @(negedge clk); chk("c_q9_rr", rr_c, 4'h4); chk("c_q9_peo", peo_c, pkt(1'b1, 1'b0, 1)); chk("c_q9_sent", sent_c, 32'd1); tick();
    @(negedge clk); chk("c_q10_rr", rr_c, 4'h0); chk("c_q10_peo", peo_c, pkt(1'b1, 1'b1, 2)); chk("c_q10_busy", busy_c, 1'b1); tick();
    @(negedge clk); chk("c_q11_done", done_c, 1'b1); chk("c_q11_sent", sent_c, 32'd3); tick();

    // Asynchronous reset after two loads, then a full rerun
    start_b = 1'b1; tick();
    start_b = 1'b0;
    @(negedge clk); chk("b_r1_rr", rr_b, 4'h0); tick();
    @(negedge clk); chk("b_r2_rr", rr_b, 4'h0); tick();
    @(negedge clk); chk("b_r3_rr", rr_b, 4'h1); tick();
    @(negedge clk); chk("b_r4_rr", rr_b, 4'h0); tick();
    @(negedge clk); chk("b_r5_rr", rr_b, 4'h2); tick();
    chk("b_r6_peo", peo_b, pkt(1'b1, 1'b0, 1));
    chk("b_r6_sent", sent_b, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_peo", peo_b, 36'h0);
    chk("arst_rr", rr_b, 4'h0);
    chk("arst_busy", busy_b, 1'b0);
    chk("arst_sent", sent_b, 32'd0);
    chk("arst_done_a", done_a, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    run_b(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
